// File: rtl/mem_port.sv
// mem_port: byte-serial load/store port between the load/store buffer and a
// byte-wide synchronous RAM.
// Loads complete with a one-cycle have_mem_out pulse that carries the
// sign- or zero-extended data. Stores produce no completion pulse.
// Optional build macro MEM_IO_STALL_EN: when it is defined, a store into the
// I/O region (addr[17:16] == IO_HI) waits while io_buffer_full is high.
module mem_port #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        req_valid,
    input  logic [4:0]  req_entry,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        mem_busy,
    output logic        have_mem_out,
    output logic [4:0]  mem_entry_out,
    output logic [31:0] mem_data_out,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_r;
    logic [4:0]  entry_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [2:0]  n_bytes_r;
    logic [2:0]  idx_r;
    logic        signed_r;
    logic [23:0] bytes_r;
    logic        ram_wr_r;
    logic        io_stall_s;
    logic [31:0] byte_addr_s;
    logic [7:0]  wbyte_s;

    // Number of bytes moved for a given size code.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            2'd0:    byte_count = 3'd1;
            2'd1:    byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

    // Assemble the earlier captured bytes with the final byte and extend to 32 bits.
    function automatic logic [31:0] extend_load(input logic [23:0] lo, input logic [7:0] last,
                                                input logic [2:0] n, input logic sgn);
        logic fill;
        fill = sgn & last[7];
        case (n)
            3'd1:    extend_load = {{24{fill}}, last};
            3'd2:    extend_load = {{16{fill}}, last, lo[7:0]};
            default: extend_load = {last, lo};
        endcase
    endfunction

    // Little-endian byte k of a store word.
    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] k);
        case (k)
            2'd0:    select_byte = word[7:0];
            2'd1:    select_byte = word[15:8];
            2'd2:    select_byte = word[23:16];
            default: select_byte = word[31:24];
        endcase
    endfunction

    // Address and store byte for the current byte index; the address wraps modulo 2^32.
    always_comb begin
        byte_addr_s = addr_r + {29'd0, idx_r};
        wbyte_s     = select_byte(wdata_r, idx_r[1:0]);
    end

`ifdef MEM_IO_STALL_EN
    assign io_stall_s = (addr_r[17:16] == IO_HI) && io_buffer_full;
`else
    logic [2:0] unused_io_s;
    assign unused_io_s = {io_buffer_full, IO_HI};
    assign io_stall_s  = 1'b0;
`endif

    // A frozen port must never strobe the RAM, even with a write pending.
    assign ram_wr = ram_wr_r & rdy_in;

    // Transaction FSM: accept, stream bytes to/from RAM, pulse completion for loads.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r       <= ST_IDLE;
            entry_r       <= 5'd0;
            addr_r        <= 32'd0;
            wdata_r       <= 32'd0;
            n_bytes_r     <= 3'd0;
            idx_r         <= 3'd0;
            signed_r      <= 1'b0;
            bytes_r       <= 24'd0;
            ram_wr_r      <= 1'b0;
            ram_a         <= 32'd0;
            ram_dout      <= 8'd0;
            mem_busy      <= 1'b0;
            have_mem_out  <= 1'b0;
            mem_entry_out <= 5'd0;
            mem_data_out  <= 32'd0;
        end else if (rdy_in) begin
            case (state_r)
                ST_IDLE: begin
                    ram_wr_r <= 1'b0;
                    if (req_valid) begin
                        entry_r   <= req_entry;
                        addr_r    <= req_addr;
                        wdata_r   <= req_wdata;
                        n_bytes_r <= byte_count(req_size);
                        signed_r  <= req_signed;
                        idx_r     <= 3'd0;
                        mem_busy  <= 1'b1;
                        state_r   <= req_wr ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (idx_r == n_bytes_r) begin
                        ram_wr_r <= 1'b0;
                        mem_busy <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else if (io_stall_s) begin
                        ram_wr_r <= 1'b0;
                    end else begin
                        ram_a    <= byte_addr_s;
                        ram_dout <= wbyte_s;
                        ram_wr_r <= 1'b1;
                        idx_r    <= idx_r + 3'd1;
                    end
                end
                ST_READ: begin
                    ram_wr_r <= 1'b0;
                    // ram_din now holds the byte addressed on the previous cycle.
                    case (idx_r)
                        3'd1:    bytes_r[7:0]   <= ram_din;
                        3'd2:    bytes_r[15:8]  <= ram_din;
                        3'd3:    bytes_r[23:16] <= ram_din;
                        default: bytes_r        <= bytes_r;
                    endcase
                    if (idx_r == n_bytes_r) begin
                        have_mem_out  <= 1'b1;
                        mem_entry_out <= entry_r;
                        mem_data_out  <= extend_load(bytes_r, ram_din, n_bytes_r, signed_r);
                        state_r       <= ST_DONE;
                    end else begin
                        ram_a <= byte_addr_s;
                        idx_r <= idx_r + 3'd1;
                    end
                end
                ST_DONE: begin
                    have_mem_out <= 1'b0;
                    mem_busy     <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    ram_wr_r     <= 1'b0;
                    have_mem_out <= 1'b0;
                    mem_busy     <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_mem_port.sv
// Directed testbench for mem_port: loads, stores, wrap, stall, reset, I/O stall.
module tb_mem_port;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        req_valid;
    logic [4:0]  req_entry;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        mem_busy;
    logic        have_mem_out;
    logic [4:0]  mem_entry_out;
    logic [31:0] mem_data_out;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        io_buffer_full;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    int pulse_count = 0;

    mem_port dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .req_valid(req_valid), .req_entry(req_entry), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_signed(req_signed), .mem_busy(mem_busy), .have_mem_out(have_mem_out),
        .mem_entry_out(mem_entry_out), .mem_data_out(mem_data_out),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // RAM contents seen by loads; data for the presented address is available in the same cycle.
    function automatic logic [7:0] ram_model(input logic [31:0] a);
        case (a)
            32'h0000_0100: ram_model = 8'h11;
            32'h0000_0101: ram_model = 8'h22;
            32'h0000_0102: ram_model = 8'h33;
            32'h0000_0103: ram_model = 8'h44;
            32'h0000_0020: ram_model = 8'h80;
            32'hFFFF_FFFE: ram_model = 8'hA1;
            32'hFFFF_FFFF: ram_model = 8'hB2;
            32'h0000_0000: ram_model = 8'hC3;
            32'h0000_0001: ram_model = 8'hD4;
            default:       ram_model = 8'h00;
        endcase
    endfunction

    assign ram_din = ram_model(ram_a);

    // Count RAM write strobes and completion pulses as the RAM would see them.
    always @(posedge clk_in) begin
        if (ram_wr) wr_count <= wr_count + 1;
        if (have_mem_out) pulse_count <= pulse_count + 1;
    end

    task automatic issue(input logic wr, input logic [4:0] tag, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic sgn);
        @(negedge clk_in);
        req_valid  = 1'b1;
        req_wr     = wr;
        req_entry  = tag;
        req_addr   = addr;
        req_wdata  = wdata;
        req_size   = size;
        req_signed = sgn;
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if ({mem_busy, have_mem_out, ram_wr} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {mem_busy, have_mem_out, ram_wr});
        end
        checks++;
        if ({mem_entry_out, mem_data_out, ram_a, ram_dout} !== 77'd0) begin
            errors++; $display("FAIL reset_values: got %h expected 0", {mem_entry_out, mem_data_out, ram_a, ram_dout});
        end
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    // Load of n bytes; optionally freeze rdy_in for stall_len cycles after edge E(stall_after).
    task automatic run_load(input string name, input logic [4:0] tag, input logic [31:0] addr,
                            input logic [1:0] size, input logic sgn, input logic [31:0] exp_data,
                            input int n, input int stall_after, input int stall_len);
        int pulses0;
        pulses0 = pulse_count;
        issue(1'b0, tag, addr, 32'd0, size, sgn);
        @(posedge clk_in); #1;
        checks++;
        if (mem_busy !== 1'b1) begin errors++; $display("FAIL %s_busy_e0: got %b expected 1", name, mem_busy); end
        @(negedge clk_in);
        req_valid = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk_in); #1;
            checks++;
            if (ram_a !== addr + 32'(k - 1)) begin
                errors++; $display("FAIL %s_addr_e%0d: got %h expected %h", name, k, ram_a, addr + 32'(k - 1));
            end
            checks++;
            if ({have_mem_out, ram_wr} !== 2'b00) begin
                errors++; $display("FAIL %s_quiet_e%0d: got %b expected 00", name, k, {have_mem_out, ram_wr});
            end
            if (k == stall_after) begin
                @(negedge clk_in);
                rdy_in = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(posedge clk_in); #1;
                    checks++;
                    if ({ram_a, have_mem_out, mem_busy} !== {addr + 32'(k - 1), 2'b01}) begin
                        errors++; $display("FAIL %s_frozen%0d: got %h/%b/%b expected %h/0/1", name, s, ram_a, have_mem_out, mem_busy, addr + 32'(k - 1));
                    end
                end
                @(negedge clk_in);
                rdy_in = 1'b1;
            end
        end
        @(posedge clk_in); #1;
        checks++;
        if ({have_mem_out, mem_entry_out, mem_data_out} !== {1'b1, tag, exp_data}) begin
            errors++; $display("FAIL %s_result: got %b/%0d/%h expected 1/%0d/%h", name, have_mem_out, mem_entry_out, mem_data_out, tag, exp_data);
        end
        @(posedge clk_in); #1;
        checks++;
        if ({have_mem_out, mem_busy} !== 2'b00) begin
            errors++; $display("FAIL %s_end: got %b expected 00", name, {have_mem_out, mem_busy});
        end
        checks++;
        if (pulse_count - pulses0 !== 1) begin
            errors++; $display("FAIL %s_pulses: got %0d expected 1", name, pulse_count - pulses0);
        end
    endtask

    task automatic test_load_word;
        run_load("ldw", 5'd5, 32'h100, 2'd2, 1'b0, 32'h4433_2211, 4, 0, 0);
    endtask

    task automatic test_load_byte;
        run_load("ldb_s", 5'd3, 32'h20, 2'd0, 1'b1, 32'hFFFF_FF80, 1, 0, 0);
        run_load("ldb_u", 5'd4, 32'h20, 2'd0, 1'b0, 32'h0000_0080, 1, 0, 0);
        run_load("ldh_s", 5'd6, 32'h102, 2'd1, 1'b1, 32'h0000_4433, 2, 0, 0);
    endtask

    task automatic test_wrap;
        run_load("wrap", 5'd9, 32'hFFFF_FFFE, 2'd3, 1'b0, 32'hD4C3_B2A1, 4, 0, 0);
    endtask

    task automatic test_store_half;
        int w0;
        w0 = wr_count;
        issue(1'b1, 5'd1, 32'h200, 32'h0000_BEEF, 2'd1, 1'b0);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        req_valid = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h200, 8'hEF}) begin
            errors++; $display("FAIL sth_e1: got %b/%h/%h expected 1/200/ef", ram_wr, ram_a, ram_dout);
        end
        @(posedge clk_in); #1;
        checks++;
        if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h201, 8'hBE}) begin
            errors++; $display("FAIL sth_e2: got %b/%h/%h expected 1/201/be", ram_wr, ram_a, ram_dout);
        end
        @(posedge clk_in); #1;
        checks++;
        if ({ram_wr, mem_busy, have_mem_out} !== 3'b000) begin
            errors++; $display("FAIL sth_e3: got %b expected 000", {ram_wr, mem_busy, have_mem_out});
        end
        @(posedge clk_in); #1;
        checks++;
        if ({ram_a, ram_wr, have_mem_out} !== {32'h201, 2'b00}) begin
            errors++; $display("FAIL sth_idle_hold: got %h/%b/%b expected 201/0/0", ram_a, ram_wr, have_mem_out);
        end
        checks++;
        if (wr_count - w0 !== 2) begin
            errors++; $display("FAIL sth_writes: got %0d expected 2", wr_count - w0);
        end
    endtask

    task automatic test_rdy_and_reset;
        int w0;
        int p0;
        run_load("rdy", 5'd7, 32'h100, 2'd2, 1'b0, 32'h4433_2211, 4, 2, 3);
        w0 = wr_count;
        p0 = pulse_count;
        issue(1'b1, 5'd2, 32'h300, 32'hCAFE_F00D, 2'd2, 1'b0);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        req_valid = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if ({ram_wr, ram_a} !== {1'b1, 32'h300}) begin
            errors++; $display("FAIL rst_pre: got %b/%h expected 1/300", ram_wr, ram_a);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        checks++;
        if ({ram_wr, mem_busy, ram_a} !== {2'b00, 32'h0}) begin
            errors++; $display("FAIL rst_async: got %b/%b/%h expected 0/0/0", ram_wr, mem_busy, ram_a);
        end
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (6) @(posedge clk_in);
        #1;
        checks++;
        if ({wr_count - w0, pulse_count - p0} !== {32'd0, 32'd0}) begin
            errors++; $display("FAIL rst_abort: got writes=%0d pulses=%0d expected 0/0", wr_count - w0, pulse_count - p0);
        end
    endtask

    task automatic test_back_to_back;
        int w0;
        w0 = wr_count;
        issue(1'b1, 5'd8, 32'h40, 32'h0000_005A, 2'd0, 1'b0);
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        checks++;
        if ({mem_busy, ram_wr, ram_dout} !== {2'b11, 8'h5A}) begin
            errors++; $display("FAIL b2b_e1: got %b/%b/%h expected 1/1/5a", mem_busy, ram_wr, ram_dout);
        end
        @(posedge clk_in); #1;
        checks++;
        if (mem_busy !== 1'b0) begin errors++; $display("FAIL b2b_return: got %b expected 0", mem_busy); end
        @(posedge clk_in); #1;
        checks++;
        if (mem_busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept: got %b expected 1", mem_busy); end
        @(negedge clk_in);
        req_valid = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if ({mem_busy, wr_count - w0} !== {1'b0, 32'd2}) begin
            errors++; $display("FAIL b2b_writes: got %b/%0d expected 0/2", mem_busy, wr_count - w0);
        end
    endtask

    task automatic test_io_stall;
        io_buffer_full = 1'b1;
        issue(1'b1, 5'd10, 32'h0003_0000, 32'h0000_0077, 2'd0, 1'b0);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        req_valid = 1'b0;
`ifdef MEM_IO_STALL_EN
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk_in); #1;
            checks++;
            if ({ram_wr, mem_busy} !== 2'b01) begin
                errors++; $display("FAIL io_stall_e%0d: got %b expected 01", k, {ram_wr, mem_busy});
            end
        end
        @(negedge clk_in);
        io_buffer_full = 1'b0;
`endif
        @(posedge clk_in); #1;
        checks++;
        if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h0003_0000, 8'h77}) begin
            errors++; $display("FAIL io_write: got %b/%h/%h expected 1/30000/77", ram_wr, ram_a, ram_dout);
        end
        @(posedge clk_in); #1;
        checks++;
        if ({ram_wr, mem_busy} !== 2'b00) begin
            errors++; $display("FAIL io_end: got %b expected 00", {ram_wr, mem_busy});
        end
        io_buffer_full = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        req_valid = 1'b0;
        req_entry = 5'd0;
        req_wr = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        req_size = 2'd0;
        req_signed = 1'b0;
        io_buffer_full = 1'b0;
        test_reset;
        test_load_word;
        test_load_byte;
        test_wrap;
        test_store_half;
        test_rdy_and_reset;
        test_back_to_back;
        test_io_stall;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port.md
MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 SHALL have parameter IO_HI, default 2'b11: value of addr[17:16] that marks the I/O region.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk_in  input  1  clock; all state on rising edge.
REQ-004 rst_in  input  1  asynchronous active-high reset.
REQ-005 rdy_in  input  1  global enable; low freezes all state.
REQ-006 req_valid  input  1  request present (driven by slb_need).
REQ-007 req_entry  input  5  ROB entry tag of request.
REQ-008 req_wr  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, little-endian.
REQ-011 req_size  input  2  0 byte, 1 half, 2/3 word.
REQ-012 req_signed  input  1  load result sign-extended when 1, zero-extended when 0.
REQ-013 mem_busy  output  1  request in progress; new requests not accepted.
REQ-014 have_mem_out  output  1  one-cycle load-completion pulse.
REQ-015 mem_entry_out  output  5  tag of completed load.
REQ-016 mem_data_out  output  32  extended load data.
REQ-017 ram_din  input  8  RAM read byte; valid one cycle after its address is sampled.
REQ-018 ram_dout  output  8  RAM write byte.
REQ-019 ram_a  output  32  RAM byte address.
REQ-020 ram_wr  output  1  RAM write strobe.
REQ-021 io_buffer_full  input  1  I/O sink cannot accept; used only under MEM_IO_STALL_EN.

Function
REQ-022 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-023 In IDLE with req_valid=1, SHALL latch tag, wr, addr, wdata, size, signed and set mem_busy=1 on the same edge (acceptance edge E0).
REQ-024 req_valid SHALL be ignored while mem_busy=1; the requester holds its request until mem_busy falls.
REQ-025 N = 1/2/4 bytes for size 0/1/2-3; byte k SHALL use address addr+k, modulo 2^32 (wrap).
REQ-026 WRITE: after edges E1..EN, ram_a=addr+k-1, ram_dout=wdata byte k-1, ram_wr=1; after E(N+1), ram_wr=0, mem_busy=0, state=IDLE; no completion pulse for stores.
REQ-027 READ: after edges E1..EN, ram_a=addr+k-1, ram_wr=0; byte k-1 SHALL be captured from ram_din at edge E(k+1).
REQ-028 DONE: at edge E(N+1) the last byte is captured, have_mem_out=1 with tag and extended data; the pulse lasts exactly one cycle; mem_busy=0 and state=IDLE after E(N+2).
REQ-029 Extension SHALL copy bit 8N-1 into bits 31:8N when signed, else zero; size-2 data is unchanged.
REQ-030 When idle, ram_wr SHALL be 0 and ram_a SHALL hold its last value.
REQ-031 rdy_in=0 SHALL hold every register, including FSM, counters and have_mem_out; ram_wr SHALL be forced to 0 combinationally.
REQ-032 A request arriving on the edge where the FSM returns to IDLE SHALL NOT be accepted until the following edge.

Reset
REQ-033 rst_in=1 SHALL asynchronously force IDLE, mem_busy=0, have_mem_out=0, mem_entry_out=0, mem_data_out=0, ram_wr=0, ram_a=0, ram_dout=0.
REQ-034 Reset mid-transaction SHALL abort it and emit no completion pulse; no further RAM write SHALL occur.

Configuration
REQ-035 With MEM_IO_STALL_EN defined, a WRITE whose addr[17:16]==IO_HI SHALL stall, holding ram_wr=0 and the byte index, while io_buffer_full=1, and resume on the first cycle it is 0.
REQ-036 With MEM_IO_STALL_EN undefined, io_buffer_full SHALL be ignored.

Verification
REQ-037 Load word, tag 5, addr 0x100, RAM bytes 11 22 33 44 -> single pulse at E5: tag 5, data 0x44332211; ram_a = 0x100..0x103 in turn.
REQ-038 Load byte signed, addr 0x20 holding 0x80 -> data 0xFFFFFF80; same load unsigned -> 0x00000080; pulse at E2.
REQ-039 Store half 0xBEEF to 0x200 -> ram_wr high for 2 cycles with (0x200,EF),(0x201,BE); no have_mem_out; mem_busy falls after E3.
REQ-040 Load word at 0xFFFFFFFE -> ram_a sequence FFFFFFFE, FFFFFFFF, 0, 1.
REQ-041 rdy_in low 3 cycles mid-read, plus reset asserted mid-store -> read result unchanged, only delayed 3 cycles; after reset no ram_wr and no pulse.
REQ-042 With MEM_IO_STALL_EN defined: store byte to 0x30000 with io_buffer_full high 4 cycles -> write occurs on the first cycle after it drops; without the macro -> write occurs after E1.
